// File: rtl/decrypt_pkg.sv
// Shared definitions for the Program 2 LFSR decryptor.
// Holds the memory geometry, the fixed tap table, the FSM state type and the
// LFSR step function used by top_level.
package decrypt_pkg;

  localparam int unsigned MEM_DEPTH = 128;
  localparam int unsigned CT_BASE   = 64;
  localparam int unsigned BLK_LEN   = 64;
  localparam int unsigned PRE_CHECK = 9;
  localparam int unsigned NUM_TAPS  = 9;
  localparam logic [6:0]  SPACE     = 7'h20;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StSrch,
    StDecr,
    StDone
  } state_e;

  // Candidate feedback patterns, tried in index order during the search.
  function automatic logic [6:0] tap_lut(input logic [3:0] idx);
    logic [6:0] tap;
    unique case (idx)
      4'd0:    tap = 7'h60;
      4'd1:    tap = 7'h48;
      4'd2:    tap = 7'h78;
      4'd3:    tap = 7'h72;
      4'd4:    tap = 7'h6A;
      4'd5:    tap = 7'h69;
      4'd6:    tap = 7'h5C;
      4'd7:    tap = 7'h7E;
      4'd8:    tap = 7'h7B;
      default: tap = 7'h60;
    endcase
    return tap;
  endfunction

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: lower half holds plaintext, upper half ciphertext.
// Ports:
//   clk    in   clock for the synchronous write
//   raddr  in   read address (combinational read)
//   rdata  out  read data
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
module data_mem
  import decrypt_pkg::*;
(
  input  logic       clk,
  input  logic [6:0] raddr,
  output logic [7:0] rdata,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata
);

  // Not reset: contents are preloaded externally before a run.
  logic [7:0] core [0:MEM_DEPTH-1];

  assign rdata = core[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      core[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/top_level.sv
// Hardwired LFSR stream-cipher decryptor.
// Recovers the seed from ciphertext byte 0 (plaintext known to be a space),
// searches the tap table against the space preamble, then decrypts 64 bytes
// from DM.core[64..127] into DM.core[0..63] and raises ack.
// Ports:
//   clk   in   clock
//   init  in   synchronous active-low reset
//   req   in   high holds the engine idle, low lets it start
//   ack   out  registered completion flag, held until reset
module top_level
  import decrypt_pkg::*;
(
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);

  state_e     state_q, state_d;
  logic [6:0] seed_q, seed_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] tap_q, tap_d;
  logic [3:0] p_q, p_d;
  // Byte index: preamble position during search, output index during decrypt.
  logic [5:0] k_q, k_d;
  logic       ack_q, ack_d;

  logic [6:0] raddr, waddr;
  logic [7:0] rdata, wdata;
  logic       we;
  logic [6:0] ct7, dec7;
  logic       unused_parity;

  data_mem DM (
    .clk   (clk),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  assign raddr         = 7'(CT_BASE) + {1'b0, k_q};
  assign ct7           = rdata[6:0];
  assign unused_parity = rdata[7];
  assign dec7          = ct7 ^ lfsr_q;
  assign waddr         = {1'b0, k_q};
  assign wdata         = {1'b0, dec7};
  assign ack           = ack_q;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    tap_d   = tap_q;
    p_d     = p_q;
    k_d     = k_q;
    we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!req) begin
          state_d = StSeed;
          k_d     = '0;
        end
      end
      StSeed: begin
        seed_d  = ct7 ^ SPACE;
        p_d     = '0;
        k_d     = 6'd1;
        lfsr_d  = lfsr_step(ct7 ^ SPACE, tap_lut(4'd0));
        state_d = StSrch;
      end
      StSrch: begin
        if (dec7 == SPACE) begin
          if (k_q == 6'(PRE_CHECK)) begin
            tap_d   = tap_lut(p_q);
            k_d     = '0;
            lfsr_d  = seed_q;
            state_d = StDecr;
          end else begin
            k_d    = k_q + 6'd1;
            lfsr_d = lfsr_step(lfsr_q, tap_lut(p_q));
          end
        end else if (p_q == 4'(NUM_TAPS - 1)) begin
          // No candidate fits the preamble: decrypt with the first tap anyway.
          tap_d   = tap_lut(4'd0);
          k_d     = '0;
          lfsr_d  = seed_q;
          state_d = StDecr;
        end else begin
          p_d    = p_q + 4'd1;
          k_d    = 6'd1;
          lfsr_d = lfsr_step(seed_q, tap_lut(p_q + 4'd1));
        end
      end
      StDecr: begin
        we     = 1'b1;
        lfsr_d = lfsr_step(lfsr_q, tap_q);
        if (k_q == 6'(BLK_LEN - 1)) begin
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ack_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      state_q <= StIdle;
      seed_q  <= '0;
      lfsr_q  <= '0;
      tap_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      tap_q   <= tap_d;
      p_q     <= p_d;
      k_q     <= k_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;
  import decrypt_pkg::*;

  logic clk;
  logic init;
  logic req;
  logic ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pt_buf [64];
  logic [7:0] ct_buf [64];
  logic [7:0] exp_q [$];
  logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

  top_level dut (
    .clk  (clk),
    .init (init),
    .req  (req),
    .ack  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  task automatic fill_text();
    string msg = "Knowledge comes, but wisdom lingers";
    for (int i = 0; i < 64; i++) begin
      pt_buf[i] = (i >= 10 && i - 10 < msg.len()) ? msg[i-10] : 8'h20;
    end
  endtask

  task automatic fill_spaces();
    for (int i = 0; i < 64; i++) pt_buf[i] = 8'h20;
  endtask

  // Ciphertext carries even parity in bit 7, optionally inverted.
  task automatic encrypt(input logic [6:0] seed, input logic [6:0] tap, input bit flip);
    logic [6:0] s = seed;
    logic [6:0] c;
    for (int i = 0; i < 64; i++) begin
      c         = pt_buf[i][6:0] ^ s;
      ct_buf[i] = {(^c) ^ flip, c};
      s         = step(s, tap);
    end
  endtask

  // Preload memory and push the model's decryption of ct_buf onto the scoreboard.
  task automatic load_and_push();
    logic [6:0] seed;
    logic [6:0] lock;
    logic [6:0] s;
    bit         ok;
    bit         found = 0;
    for (int i = 0; i < 64; i++) begin
      dut.DM.core[64+i] <= ct_buf[i];
      dut.DM.core[i]    <= 8'hAA;
    end
    #1;
    seed = ct_buf[0][6:0] ^ 7'h20;
    lock = taps[0];
    for (int p = 0; p < 9; p++) begin
      if (!found) begin
        s  = seed;
        ok = 1;
        for (int k = 1; k <= 9; k++) begin
          s = step(s, taps[p]);
          if (ok && ((ct_buf[k][6:0] ^ s) != 7'h20)) ok = 0;
        end
        if (ok) begin
          lock  = taps[p];
          found = 1;
        end
      end
    end
    s = seed;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({1'b0, ct_buf[i][6:0] ^ s});
      s = step(s, lock);
    end
  endtask

  task automatic do_reset();
    req  = 1'b1;
    init = 1'b0;
    @(posedge clk);
    #1;
    init = 1'b1;
  endtask

  task automatic wait_ack(input string tag);
    int cycles = 0;
    req = 1'b0;
    while (!ack && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_latency"}, 32'(cycles <= 148), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_underflow"}, 32'd1, 32'd0);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("%s_byte%0d", tag, i), 32'(dut.DM.core[i]), 32'(e));
    end
  endtask

  task automatic run_block(input string tag, input logic [6:0] seed, input logic [6:0] tap,
                           input bit flip);
    do_reset();
    encrypt(seed, tap, flip);
    load_and_push();
    wait_ack(tag);
    drain(tag);
  endtask

  initial begin
    int n;
    init = 1'b0;
    req  = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(StIdle));
    init = 1'b1;

    // 1: text message, tap 60, seed 01
    fill_text();
    run_block("text_t60", 7'h01, 7'h60, 1'b0);

    // 2: every tap, seed 7F, all spaces
    fill_spaces();
    for (int t = 0; t < 9; t++) begin
      run_block($sformatf("space_t%0d", t), 7'h7F, taps[t], 1'b0);
    end

    // 3: seed 20 gives a zero first ciphertext byte
    fill_text();
    run_block("seed20_t7b", 7'h20, 7'h7B, 1'b0);

    // 4: req held high keeps the engine idle
    fill_text();
    do_reset();
    encrypt(7'h33, 7'h72, 1'b0);
    load_and_push();
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (ack) break;
    end
    check("hold_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("hold_untouched%0d", i), 32'(dut.DM.core[i]), 32'hAA);
    end
    wait_ack("hold_release");
    drain("hold_release");

    // 5: reset in the middle of decryption, then rerun
    fill_text();
    do_reset();
    encrypt(7'h5A, 7'h69, 1'b0);
    load_and_push();
    req = 1'b0;
    n   = 0;
    while (dut.state_q != StDecr && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_reached_decr", 32'(dut.state_q), 32'(StDecr));
    repeat (10) @(posedge clk);
    #1;
    req  = 1'b1;
    init = 1'b0;
    @(posedge clk);
    #1;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(StIdle));
    init = 1'b1;
    wait_ack("abort_rerun");
    drain("abort_rerun");

    // 6: inverted parity bits must not affect the result
    fill_text();
    run_block("parity_flip", 7'h01, 7'h60, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
